twiddle_loader: RTL and testbench
=================================

// Module: twiddle_loader
// PURPOSE
//  Writer side of the butterfly coefficient register. For one FFT stage it walks
//  butterflies k=0..N/2-1 and fetches each twiddle (C,S) from an external sync ROM.
//  It forms C, C+S and C-S and presents them with a one-cycle write strobe to the
//  coefficient register. It then waits for the butterfly datapath to request the next one.
// PARAMETERS
//  MSB    16  coefficient word width (two's complement)
//  N      16  FFT points (power of two, >=4)
//  LOG2N  4   log2(N); ROM address width = LOG2N-1 (N/2 entries)
// PORTS
//  clk         in   1          single clock, all logic on posedge
//  rst_n       in   1          synchronous reset, active-low
//  i_start     in   1          begin stage sequence (sampled only in IDLE)
//  i_stage     in   LOG2N      stage index s; values >= LOG2N treated as LOG2N-1
//  i_next      in   1          datapath done with current coeff (sampled only in HOLD)
//  o_rom_addr  out  LOG2N-1    twiddle ROM address
//  i_rom_C     in   MSB        ROM cosine, valid 1 cycle after address
//  i_rom_S     in   MSB        ROM sine, valid 1 cycle after address
//  o_we        out  1          write strobe to coefficient register
//  o_C         out  MSB        cosine
//  o_CpS       out  MSB        cosine + sine
//  o_CmS       out  MSB        cosine - sine
//  o_busy      out  1          high whenever state != IDLE
//  o_done      out  1          one-cycle pulse after last coefficient consumed
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): state=IDLE, k=0, stage reg=0, o_we=0, o_done=0,
//    o_C/o_CpS/o_CmS=0, o_rom_addr=0. Reset mid-sequence aborts at once; no o_done.
//  - FSM: IDLE -> FETCH -> LOAD -> WRITE -> HOLD -> (FETCH | IDLE).
//    IDLE : i_start=1 latches clamped i_stage, k<=0, goto FETCH.
//           i_start in any other state is ignored.
//    FETCH: o_rom_addr = (k & ((1<<s)-1)) << (LOG2N-1-s); 1 cycle.
//    LOAD : ROM data valid. Registers: o_C<=C, o_CpS<=C+S, o_CmS<=C-S. 1 cycle.
//    WRITE: o_we=1 for exactly this cycle; outputs stable. Goto HOLD.
//    HOLD : o_we=0. Wait for i_next=1.
//           If k==N/2-1: goto IDLE and pulse o_done the same cycle IDLE is entered.
//           Else k<=k+1, goto FETCH.
//  - Latency: i_start sampled at edge t -> o_we high in cycle t+3.
//    i_next sampled at edge u -> next o_we in cycle u+3.
//  - o_rom_addr holds its last value outside FETCH (ROM read is harmless).
//  - Arithmetic: C+S and C-S are truncated to MSB bits (mod 2^MSB wrap, no saturation).
//  - o_C/o_CpS/o_CmS change only at the end of LOAD; they hold through HOLD and IDLE.
//  - i_next outside HOLD is ignored. i_next and i_start together in HOLD: only
//    i_next acts.
//  - o_done and i_start in the same cycle: the new start is accepted on the following
//    edge (IDLE is entered first).
//  - Stage 0 yields address 0 for every k. Stage LOG2N-1 yields address k.
// STRUCTURE
//  - Shared include fft_defs.vh: MSB/N/LOG2N defaults, FSM state localparams
//    (IDLE, FETCH, LOAD, WRITE, HOLD, 3-bit), twiddle index function.
//  - One sub-module: twiddle_addr_gen (combinational k,s -> ROM address).
//  - FSM, k counter and output registers stay in twiddle_loader.
// TESTING
//  1 Reset: hold rst_n=0 3 cycles with random inputs -> all outputs 0, o_busy=0.
//  2 N=16, s=3, ROM model addr->C=addr*0x100, S=addr. i_next 2 cycles after each
//    o_we -> 8 strobes, addresses 0..7. Addr 5: o_C=0x0500, o_CpS=0x0505,
//    o_CmS=0x04FB. o_done once, after the 8th i_next.
//  3 s=1 -> address sequence 0,4,0,4,0,4,0,4. s=0 -> all 0.
//    i_stage=9 -> same sequence as s=3.
//  4 Wrap: C=0x7FFF, S=0x0001 -> o_CpS=0x8000, o_CmS=0x7FFE.
//    C=0x8000, S=0x0001 -> o_CmS=0x7FFF.
//  5 Timing: i_start at edge t -> o_we only in cycle t+3. i_next held high in LOAD and
//    WRITE -> ignored; consumed only in HOLD. i_start while busy -> ignored.
//  6 Reset asserted in HOLD at k=4 -> next cycle IDLE, o_we=0, no o_done.
//    A new i_start restarts at k=0.

Source files
------------

// File: rtl/twiddle_loader_pkg.sv
// Shared definitions for the twiddle loader: parameter defaults, FSM states and
// the butterfly-to-twiddle index mapping.
// Ports: none (package).
package twiddle_loader_pkg;

    localparam int DEF_MSB   = 16;
    localparam int DEF_N     = 16;
    localparam int DEF_LOG2N = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LOAD  = 3'd2,
        WRITE = 3'd3,
        HOLD  = 3'd4
    } state_t;

    // Twiddle ROM index for butterfly k of stage s: only the low s bits of k
    // select a distinct twiddle; they are spread across the N/2-entry table.
    function automatic int unsigned twiddle_idx(input int unsigned k,
                                                input int unsigned s,
                                                input int unsigned log2n);
        int unsigned mask;
        mask = (32'd1 << s) - 32'd1;
        return (k & mask) << (log2n - 32'd1 - s);
    endfunction

endpackage

// File: rtl/twiddle_addr_gen.sv
// Combinational twiddle ROM address from butterfly index and stage.
// Latency: zero (pure combinational).
// Backpressure: none. Ports: k (butterfly index), stage (clamped stage), addr (ROM address).
module twiddle_addr_gen
    import twiddle_loader_pkg::*;
#(
    parameter int LOG2N = DEF_LOG2N
) (
    input  logic [LOG2N-2:0] k,
    input  logic [LOG2N-1:0] stage,
    output logic [LOG2N-2:0] addr
);

    assign addr = (LOG2N-1)'(twiddle_idx(32'(k), 32'(stage), 32'(LOG2N)));

endmodule

// File: rtl/twiddle_loader.sv
// Walks butterflies of one FFT stage, fetches (C,S) from a sync ROM, writes C, C+S, C-S.
// Latency: i_start (IDLE) or i_next (HOLD) sampled at edge t -> o_we high in cycle t+3.
// Backpressure: holds each coefficient in HOLD until i_next; o_done pulses on entering IDLE.
// Ports: clk/rst_n (sync active-low); i_start/i_stage/i_next control; o_rom_addr,
//        i_rom_C/i_rom_S ROM side; o_we/o_C/o_CpS/o_CmS register write; o_busy/o_done status.
module twiddle_loader
    import twiddle_loader_pkg::*;
#(
    parameter int MSB   = DEF_MSB,
    parameter int N     = DEF_N,
    parameter int LOG2N = DEF_LOG2N
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic [LOG2N-1:0] i_stage,
    input  logic             i_next,
    output logic [LOG2N-2:0] o_rom_addr,
    input  logic [MSB-1:0]   i_rom_C,
    input  logic [MSB-1:0]   i_rom_S,
    output logic             o_we,
    output logic [MSB-1:0]   o_C,
    output logic [MSB-1:0]   o_CpS,
    output logic [MSB-1:0]   o_CmS,
    output logic             o_busy,
    output logic             o_done
);

    localparam int               ADDR_W    = LOG2N - 1;
    localparam logic [LOG2N-1:0] STAGE_MAX = LOG2N'(LOG2N - 1);
    localparam logic [ADDR_W-1:0] K_LAST   = ADDR_W'(N / 2 - 1);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] k;
    logic [LOG2N-1:0]  stage;
    logic [LOG2N-1:0]  stage_clamped;
    logic [ADDR_W-1:0] addr_gen;
    logic [ADDR_W-1:0] addr_q;
    logic              start_acc;
    logic              next_acc;
    logic              k_last;

    assign stage_clamped = (i_stage > STAGE_MAX) ? STAGE_MAX : i_stage;
    assign start_acc     = (state == IDLE) && i_start;
    assign next_acc      = (state == HOLD) && i_next;
    assign k_last        = (k == K_LAST);

    twiddle_addr_gen #(
        .LOG2N (LOG2N)
    ) u_addr_gen (
        .k     (k),
        .stage (stage),
        .addr  (addr_gen)
    );

    // Address is driven live during FETCH so the sync ROM sees it that cycle;
    // outside FETCH the last fetched address is held.
    assign o_rom_addr = (state == FETCH) ? addr_gen : addr_q;
    assign o_we       = (state == WRITE);
    assign o_busy     = (state != IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (i_start) state_nxt = FETCH;
            FETCH:   state_nxt = LOAD;
            LOAD:    state_nxt = WRITE;
            WRITE:   state_nxt = HOLD;
            HOLD:    if (i_next) state_nxt = k_last ? IDLE : FETCH;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            k      <= '0;
            stage  <= '0;
            addr_q <= '0;
            o_C    <= '0;
            o_CpS  <= '0;
            o_CmS  <= '0;
            o_done <= 1'b0;
        end else begin
            if (start_acc) begin
                stage <= stage_clamped;
                k     <= '0;
            end else if (next_acc && !k_last) begin
                k <= k + 1'b1;
            end
            if (state == FETCH) begin
                addr_q <= addr_gen;
            end
            // Sums wrap modulo 2^MSB by design.
            if (state == LOAD) begin
                o_C   <= i_rom_C;
                o_CpS <= i_rom_C + i_rom_S;
                o_CmS <= i_rom_C - i_rom_S;
            end
            o_done <= next_acc && k_last;
        end
    end

endmodule

// File: tb/tb_twiddle_loader.sv
module tb_twiddle_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_start;
    logic [3:0]  i_stage;
    logic        i_next;
    logic [2:0]  o_rom_addr;
    logic [15:0] i_rom_C;
    logic [15:0] i_rom_S;
    logic        o_we;
    logic [15:0] o_C;
    logic [15:0] o_CpS;
    logic [15:0] o_CmS;
    logic        o_busy;
    logic        o_done;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;

    logic        rom_force = 1'b0;
    logic [15:0] force_c   = '0;
    logic [15:0] force_s   = '0;

    typedef struct {
        logic [2:0]  addr;
        logic [15:0] c;
        logic [15:0] cps;
        logic [15:0] cms;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [3:0]      stage;
        logic [7:0][2:0] addrs;
    } vec_t;
    vec_t vecs[5];

    twiddle_loader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_start    (i_start),
        .i_stage    (i_stage),
        .i_next     (i_next),
        .o_rom_addr (o_rom_addr),
        .i_rom_C    (i_rom_C),
        .i_rom_S    (i_rom_S),
        .o_we       (o_we),
        .o_C        (o_C),
        .o_CpS      (o_CpS),
        .o_CmS      (o_CmS),
        .o_busy     (o_busy),
        .o_done     (o_done)
    );

    always #5 clk = ~clk;

    // Sync ROM: C = addr*0x100, S = addr, or forced constants.
    always @(posedge clk) begin
        i_rom_C <= rom_force ? force_c : {5'd0, o_rom_addr, 8'h00};
        i_rom_S <= rom_force ? force_s : {13'd0, o_rom_addr};
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Scoreboard consumer on the inactive edge.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && o_we === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_we", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("we_addr", 32'(o_rom_addr), 32'(e.addr));
                chk("we_C",    32'(o_C),        32'(e.c));
                chk("we_CpS",  32'(o_CpS),      32'(e.cps));
                chk("we_CmS",  32'(o_CmS),      32'(e.cms));
            end
        end
        if (o_done === 1'b1) done_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_we(output int n);
        n = 0;
        while (o_we !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        if (o_we !== 1'b1) chk("we_timeout", 32'd0, 32'd1);
    endtask

    task automatic push_exp(input logic [2:0] a, input logic [15:0] c,
                            input logic [15:0] cps, input logic [15:0] cms);
        exp_t e;
        e.addr = a; e.c = c; e.cps = cps; e.cms = cms;
        sb.push_back(e);
    endtask

    task automatic push_normal(input logic [2:0] a);
        logic [15:0] aa;
        aa = {13'd0, a};
        push_exp(a, aa << 8, (aa << 8) + aa, (aa << 8) - aa);
    endtask

    // Full stage sequence; i_next asserted two cycles after each strobe.
    task automatic run_seq(input logic [3:0] stage, input logic [7:0][2:0] addrs,
                           input logic frc, input logic [15:0] cps, input logic [15:0] cms);
        int n;
        for (int j = 0; j < 8; j++) begin
            if (frc) push_exp(addrs[j], force_c, cps, cms);
            else     push_normal(addrs[j]);
        end
        i_start = 1'b1;
        i_stage = stage;
        step();
        i_start = 1'b0;
        chk("start_busy", 32'(o_busy), 32'd1);
        chk("done_clears", 32'(o_done), 32'd0);
        for (int j = 0; j < 8; j++) begin
            wait_we(n);
            chk("we_latency", 32'(n), 32'd2);
            step();
            step();
            chk("hold_we_low", 32'(o_we), 32'd0);
            i_next = 1'b1;
            step();
            i_next = 1'b0;
        end
        chk("done_pulse", 32'(o_done), 32'd1);
        chk("idle_busy", 32'(o_busy), 32'd0);
        chk("sb_drained", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int n;
        int done_snap;

        vecs[0].stage = 4'd3; vecs[0].addrs = {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
        vecs[1].stage = 4'd1; vecs[1].addrs = {3'd4, 3'd0, 3'd4, 3'd0, 3'd4, 3'd0, 3'd4, 3'd0};
        vecs[2].stage = 4'd0; vecs[2].addrs = {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
        vecs[3].stage = 4'd9; vecs[3].addrs = {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
        vecs[4].stage = 4'd2; vecs[4].addrs = {3'd6, 3'd4, 3'd2, 3'd0, 3'd6, 3'd4, 3'd2, 3'd0};

        // Reset with random inputs.
        rst_n = 1'b0;
        for (int c = 0; c < 3; c++) begin
            i_start = 1'($urandom);
            i_next  = 1'($urandom);
            i_stage = 4'($urandom);
            step();
            chk("rst_we",   32'(o_we),       32'd0);
            chk("rst_busy", 32'(o_busy),     32'd0);
            chk("rst_done", 32'(o_done),     32'd0);
            chk("rst_addr", 32'(o_rom_addr), 32'd0);
            chk("rst_C",    32'(o_C),        32'd0);
            chk("rst_CpS",  32'(o_CpS),      32'd0);
            chk("rst_CmS",  32'(o_CmS),      32'd0);
        end
        i_start = 1'b0;
        i_next  = 1'b0;
        i_stage = 4'd0;
        rst_n   = 1'b1;
        step();

        // Back-to-back sequences: each new start lands in the o_done cycle.
        for (int v = 0; v < 5; v++) begin
            run_seq(vecs[v].stage, vecs[v].addrs, 1'b0, 16'h0, 16'h0);
        end

        // Wrap-around arithmetic.
        rom_force = 1'b1; force_c = 16'h7FFF; force_s = 16'h0001;
        run_seq(4'd0, vecs[2].addrs, 1'b1, 16'h8000, 16'h7FFE);
        force_c = 16'h8000; force_s = 16'h0001;
        run_seq(4'd0, vecs[2].addrs, 1'b1, 16'h8001, 16'h7FFF);
        rom_force = 1'b0;
        step();
        chk("outputs_hold_idle", 32'(o_CmS), 32'h7FFF);

        // Timing, ignored i_next / i_start, then reset in HOLD at k=4.
        for (int k = 0; k < 5; k++) push_normal(3'(k));
        i_start = 1'b1;
        i_stage = 4'd3;
        step();                 // FETCH k=0
        i_next = 1'b1;          // held through LOAD and WRITE
        chk("t_fetch_we", 32'(o_we), 32'd0);
        step();                 // LOAD
        chk("t_load_we", 32'(o_we), 32'd0);
        step();                 // WRITE
        chk("t_write_we", 32'(o_we), 32'd1);
        step();                 // HOLD, i_next now consumed at next edge
        i_start = 1'b0;
        chk("t_hold_we", 32'(o_we), 32'd0);
        chk("t_hold_busy", 32'(o_busy), 32'd1);
        step();                 // FETCH k=1
        i_next = 1'b0;
        wait_we(n);
        chk("t_next_latency", 32'(n), 32'd2);
        for (int k = 1; k < 4; k++) begin
            step();
            i_next = 1'b1;
            step();
            i_next = 1'b0;
            wait_we(n);
            chk("t_next_latency", 32'(n), 32'd2);
        end
        step();                 // HOLD at k=4
        chk("abort_in_hold", 32'(o_busy & ~o_we), 32'd1);
        done_snap = done_cnt;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("abort_busy", 32'(o_busy), 32'd0);
        chk("abort_we",   32'(o_we),   32'd0);
        chk("abort_done", 32'(o_done), 32'd0);
        chk("abort_C",    32'(o_C),    32'd0);
        chk("abort_sb",   32'(sb.size()), 32'd0);
        step();
        step();
        chk("abort_no_done", 32'(done_cnt - done_snap), 32'd0);

        // Restart after abort begins at k=0.
        run_seq(vecs[0].stage, vecs[0].addrs, 1'b0, 16'h0, 16'h0);
        step();
        step();
        chk("done_total", 32'(done_cnt), 32'd8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
